// File: rtl/axis_byte_fifo.sv
// axis_byte_fifo
//   Single-clock AXI4-Stream FIFO with first-word-fall-through read side and a
//   registered fill level.
//
//   Build option: define AXIS_FIFO_OUTREG_EN to drive m_axis_tdata and
//   m_axis_tvalid straight from flops. Capacity then becomes DEPTH+1 and
//   empty-to-valid latency becomes 2 cycles. Without it, m_axis_tdata is a
//   combinational read of the array and latency is 1 cycle.
//
//   Parameters
//     DATA_WIDTH  tdata width on both sides
//     DEPTH       storage-array entries (power of 2, >= 2)
//     LW          width of level (derived, leave at default)
//
//   Ports
//     aclk            clock, rising edge
//     aresetn         asynchronous active-low reset
//     s_axis_tdata    write data
//     s_axis_tvalid   write request
//     s_axis_tready   FIFO can accept a word (registered)
//     m_axis_tdata    oldest held word
//     m_axis_tvalid   read data valid
//     m_axis_tready   consumer accepts the word
//     level           words currently held (registered)
module axis_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int LW         = $clog2(DEPTH + 2)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [LW-1:0]         level
);

    localparam int AW = $clog2(DEPTH);
`ifdef AXIS_FIFO_OUTREG_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = DEPTH;
`endif
    localparam logic [LW-1:0] CAP_L = LW'(CAP);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_next;
    logic                  push;
    logic                  pop;
    logic                  rd_en;    // a word leaves the array this cycle

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        level_next = level + LW'(push) - LW'(pop);
    end

    // s_axis_tready is computed from level_next so it depends only on flops
    // and this cycle's handshakes, never on a combinational m_axis_tready path
    // to the write side.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level         <= level_next;
            s_axis_tready <= (level_next < CAP_L);
        end
    end

    // Storage array: not reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

`ifdef AXIS_FIFO_OUTREG_EN
    // level counts the output register too, so the array occupancy is kept
    // separately to decide when the output register can be refilled.
    logic [LW-1:0] arr_cnt;

    assign rd_en = (arr_cnt != '0) && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arr_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            arr_cnt <= arr_cnt + LW'(push) - LW'(rd_en);
            if (rd_en) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= mem[rd_ptr];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
`else
    assign rd_en         = pop;
    assign m_axis_tvalid = (level != '0);
    // Gated so the output reads zero while empty or in reset.
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_axis_byte_fifo.sv
module tb_axis_byte_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 2);
`ifdef AXIS_FIFO_OUTREG_EN
    localparam int CAP = DEPTH + 1;
    localparam int LAT = 2;
`else
    localparam int CAP = DEPTH;
    localparam int LAT = 1;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [LW-1:0] level;

    axis_byte_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .level         (level)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          m_lvl = 0;
    bit          m_rdy = 1'b0;
    int          max_lvl = 0;
    int          first_v = -1;
    int          outs = 0;
    logic [7:0]  last_out = '0;
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;
    logic [7:0]  exp_b;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge aclk) cyc++;

    // Scoreboard input side: every accepted word is expected out later.
    always @(negedge aclk) begin
        if (!aresetn) exp_q.delete();
        else if (s_tvalid && s_tready) exp_q.push_back(s_tdata);
    end

    // Scoreboard output side: compares every popped word against the queue.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", int'(m_tvalid), 1);
                check("hold_data", int'(m_tdata), int'(stall_data));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("data", int'(m_tdata), int'(exp_b));
                end
                outs++;
                last_out = m_tdata;
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = m_tdata;
        end
    end

    // Occupancy model: level follows accepted pushes minus pops, ready is
    // level < CAP one cycle later.
    always @(negedge aclk) begin
        if (!aresetn) begin
            check("rst_s_tready", int'(s_tready), 0);
            check("rst_m_tvalid", int'(m_tvalid), 0);
            check("rst_m_tdata", int'(m_tdata), 0);
            check("rst_level", int'(level), 0);
            m_lvl = 0;
            m_rdy = 1'b0;
        end else begin
            check("level", int'(level), m_lvl);
            check("s_tready", int'(s_tready), int'(m_rdy));
`ifdef AXIS_FIFO_OUTREG_EN
            check("valid_without_level", int'(m_tvalid && level == 0), 0);
`else
            check("m_tvalid", int'(m_tvalid), int'(m_lvl > 0));
`endif
            check("level_bound", int'(int'(level) <= CAP), 1);
            if (m_tvalid && first_v < 0) first_v = cyc;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            m_lvl = m_lvl + int'(s_tvalid && m_rdy) - int'(m_tvalid && m_tready);
            m_rdy = (m_lvl < CAP);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Push n words (value base+i) with the current m_tready, bounded.
    task automatic push_n(input int n, input int base);
        int  sent;
        bit  acc;
        sent = 0;
        s_tvalid = 1'b1;
        for (int k = 0; k < 200 && sent < n; k++) begin
            s_tdata = 8'(base + sent);
            @(negedge aclk);
            acc = s_tready;
            step();
            if (acc) sent++;
        end
        s_tvalid = 1'b0;
        check("push_n_count", sent, n);
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (level == '0 && !m_tvalid) break;
            step();
        end
        check("drain_level", int'(level), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        int sent;
        int outs0;
        bit acc;

        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();
        check("ready_after_reset", int'(s_tready), 1);

        // Basic flow
        m_tready = 1'b1;
        max_lvl  = 0;
        first_v  = -1;
        c0       = cyc;
        s_tvalid = 1'b1;
        s_tdata  = 8'h11; step();
        s_tdata  = 8'h22; step();
        s_tdata  = 8'h33; step();
        s_tvalid = 1'b0;
        repeat (5) step();
        check("first_valid_latency", first_v - c0, LAT);
        check("basic_peak_level", max_lvl, LAT);
        check("basic_outs", outs, 3);
        check("basic_last", int'(last_out), 8'h33);

        // Fill to full
        m_tready = 1'b0;
        push_n(CAP, 0);
        check("full_level", int'(level), CAP);
        check("full_ready", int'(s_tready), 0);
        s_tvalid = 1'b1;
        s_tdata  = 8'hEE;
        repeat (4) step();
        s_tvalid = 1'b0;
        check("full_ignore_level", int'(level), CAP);
        check("full_head", int'(m_tdata), 0);

        // Single pop from full, then one push refills
        outs0    = outs;
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("single_pop_outs", outs - outs0, 1);
        check("single_pop_value", int'(last_out), 0);
        check("ready_after_pop", int'(s_tready), 1);
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        step();
        s_tvalid = 1'b0;
        check("refull_ready", int'(s_tready), 0);
        check("refull_level", int'(level), CAP);
        drain();

        // Simultaneous push and pop at level 5
        m_tready = 1'b0;
        push_n(5, 8'h40);
        repeat (2) step();
        check("steady_start", int'(level), 5);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_tdata = 8'($urandom);
            step();
            check("steady_level", int'(level), 5);
        end
        drain();

        // Random stream under 2-low/6-high back-pressure
        sent = 0;
        for (int k = 0; k < 3000 && sent < 100; k++) begin
            m_tready = ((cyc % 8) >= 2);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = 8'($urandom);
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            step();
            if (acc) sent++;
        end
        check("osc_sent", sent, 100);
        drain();

        // Reset mid-stream at level 7
        m_tready = 1'b0;
        push_n(7, 8'h70);
        check("pre_reset_level", int'(level), 7);
        aresetn = 1'b0;
        #1;
        check("async_rst_level", int'(level), 0);
        check("async_rst_valid", int'(m_tvalid), 0);
        check("async_rst_ready", int'(s_tready), 0);
        repeat (3) step();
        aresetn = 1'b1;
        step();
        outs0    = outs;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hA5;
        step();
        s_tvalid = 1'b0;
        repeat (4) step();
        check("post_reset_outs", outs - outs0, 1);
        check("post_reset_first", int'(last_out), 8'hA5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_byte_fifo.md
# axis_byte_fifo

Synchronous AXI4-Stream FIFO between the 8-bit stream master and the stream slave, with both running on the same `aclk`. It absorbs `tready` back-pressure from the consumer, which toggles in an OSC pattern (2 low / 6 high), so the producer can keep streaming through the gaps. It provides first-word-fall-through data on the master side and reports its fill level for scoreboards and debug.

## Interface
- `DATA_WIDTH`, default 8: width of `tdata` on both sides.
- `DEPTH`, default 16: storage-array entries. Must be a power of 2 and ≥ 2.
- `LW`, default `$clog2(DEPTH+2)`: width of `level`. Derived; do not override.

Ports:
- `aclk` in 1: single clock. All logic is rising-edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `DATA_WIDTH`: write data.
- `s_axis_tvalid` in 1: write request.
- `s_axis_tready` out 1: FIFO can accept data.
- `m_axis_tdata` out `DATA_WIDTH`: read data.
- `m_axis_tvalid` out 1: read data valid.
- `m_axis_tready` in 1: consumer accepts data.
- `level` out `LW`: number of words currently held, registered.

## Operation
- Push occurs when `s_axis_tvalid && s_axis_tready`. Pop occurs when `m_axis_tvalid && m_axis_tready`.
- Storage is a `DEPTH`-entry array with `$clog2(DEPTH)`-bit write and read pointers. Pointers wrap naturally from `DEPTH-1` to 0.
- `s_axis_tready` is a register that equals `level_next < CAP`.
  - `CAP` is `DEPTH`, or `DEPTH+1` with the output register compiled in.
  - No combinational path exists from `m_axis_tready` to `s_axis_tready`.
- `m_axis_tvalid` is high exactly when `level > 0`. `m_axis_tdata` shows the oldest word.
- While `m_axis_tvalid && !m_axis_tready`, `m_axis_tdata` and `m_axis_tvalid` hold stable.
- `level_next` is computed as follows:
  - `level + push - pop`.
  - Push and pop in the same cycle leave `level` unchanged.
  - Overflow and underflow are impossible by construction.
- Full state: `s_axis_tready` is 0. A pop in cycle N raises `s_axis_tready` in cycle N+1.
- Empty state: there is no bypass. A push in cycle N makes `m_axis_tvalid` high in cycle N+1.
- Data order is strictly FIFO. No data is dropped or duplicated.

## Timing
- Reset values, held while `aresetn` is low:
  - `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `level` = 0.
  - Pointers are 0.
  - Array contents are not reset.
- In the first rising edge after `aresetn` deasserts, `s_axis_tready` goes to 1.
- Reset asserted mid-stream: all held words are discarded immediately (asynchronously) and outputs go to their reset values. After release, the FIFO restarts empty.
- Latency without the output register: 1 cycle from push to `m_axis_tvalid`. Sustained throughput is 1 word/cycle in each direction.
- Latency with the output register: 2 cycles from push into an empty FIFO to `m_axis_tvalid`. Throughput remains 1 word/cycle.

## Configuration
- Macro `AXIS_FIFO_OUTREG_EN`.
- Defined:
  - `m_axis_tdata` and `m_axis_tvalid` come directly from flops. The output register is refilled from the array whenever it is empty or being popped.
  - `CAP` is `DEPTH+1`. `level` counts array entries plus the output register.
  - Empty-to-valid latency is 2 cycles.
- Undefined:
  - `m_axis_tdata` is the array read at the read pointer, a combinational mux.
  - `CAP` is `DEPTH`. Empty-to-valid latency is 1 cycle.
- The handshake rules, ordering and reset behaviour are identical in both builds.

## Test plan
- Basic flow: reset, push 0x11, 0x22, 0x33 back-to-back with `m_axis_tready` = 1.
  - Output is 0x11, 0x22, 0x33 in order.
  - First `m_axis_tvalid` appears 1 cycle after the first push (2 cycles with `_EN`).
  - `level` peaks at 1 (2 with `_EN`).
- Fill to full: hold `m_axis_tready` = 0 and push 0x00..0x0F.
  - After 16 pushes (17 with `_EN`), `s_axis_tready` = 0 and `level` = `CAP`.
  - Further `s_axis_tvalid` is ignored.
- Full with a single pop: from full, pulse `m_axis_tready` for 1 cycle.
  - 0x00 is popped.
  - `s_axis_tready` = 1 on the next cycle.
  - One push is accepted, then `s_axis_tready` returns to 0.
- Simultaneous push and pop at `level` = 5 for 20 cycles: `level` stays 5 throughout, and the data sequence is preserved.
- Wrap-around under OSC back-pressure: send 100 random bytes while `m_axis_tready` runs a 2-low/6-high pattern.
  - The output stream equals the input stream.
  - `level` never exceeds `CAP`.
- Reset mid-stream: at `level` = 7, pulse `aresetn` low for 3 cycles.
  - During reset, outputs are 0 and `level` = 0.
  - After release, the next pushed byte (0xA5) is the first byte out.
